// File: rtl/depthconv_scheduler.sv
// Depthwise-conv piece/part scheduler: sequences feature loads and weight
// calculations over in_piece x part_num steps and drives per-part lane enables.
module depthconv_scheduler (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_inst_valid,
  output logic       o_inst_ready,
  input  logic [7:0] i_in_piece,
  input  logic [4:0] i_part_num,
  input  logic [3:0] i_last_part,
  output logic       o_load_req,
  input  logic       i_feature_load_end,
  output logic       o_start_calculate,
  input  logic       i_group_end,
  output logic [7:0] o_pe_en,
  input  logic       i_abort,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err
);

  localparam int unsigned PIECE_W = 8;
  localparam int unsigned PART_W  = 5;
  localparam int unsigned LAST_W  = 4;
  localparam int unsigned LANES   = 8;

  typedef enum logic [2:0] {
    IDLE, LOAD, WAIT_LOAD, START, WAIT_CALC, NEXT, DONE
  } state_t;

  state_t              state_q, state_d;
  logic [PIECE_W-1:0]  in_piece_q, in_piece_d;
  logic [PART_W-1:0]   part_num_q, part_num_d;
  logic [LAST_W-1:0]   last_part_q, last_part_d;
  logic [PIECE_W-1:0]  piece_cnt_q, piece_cnt_d;
  logic [PART_W-1:0]   part_cnt_q, part_cnt_d;
  logic                err_q, err_d;

  logic                load_req_d, start_calc_d, busy_d, done_d, err_out_d, ready_d;
  logic [LANES-1:0]    pe_en_d;

  // Lane enable for a part: all lanes, except the final part keeps only last_part lanes.
  function automatic logic [LANES-1:0] lane_mask(input logic [PART_W-1:0] part_cnt,
                                                 input logic [PART_W-1:0] part_num,
                                                 input logic [LAST_W-1:0] last_part);
    logic [LANES-1:0] m;
    m = {LANES{1'b1}};
    if (part_cnt == PART_W'(part_num - PART_W'(1))) begin
      if (last_part != LAST_W'(0) && last_part <= LAST_W'(LANES)) begin
        m = {LANES{1'b1}} >> LAST_W'(LAST_W'(LANES) - last_part);
      end
    end
    return m;
  endfunction

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_d     = state_q;
    in_piece_d  = in_piece_q;
    part_num_d  = part_num_q;
    last_part_d = last_part_q;
    piece_cnt_d = piece_cnt_q;
    part_cnt_d  = part_cnt_q;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        if (i_inst_valid) begin
          in_piece_d  = i_in_piece;
          part_num_d  = i_part_num;
          last_part_d = i_last_part;
          piece_cnt_d = '0;
          part_cnt_d  = '0;
          if (i_in_piece == PIECE_W'(0) || i_part_num == PART_W'(0)) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            state_d = LOAD;
          end
        end
      end
      LOAD:      state_d = WAIT_LOAD;
      WAIT_LOAD: if (i_feature_load_end) state_d = START;
      START:     state_d = WAIT_CALC;
      WAIT_CALC: if (i_group_end) state_d = NEXT;
      NEXT: begin
        if (piece_cnt_q == PIECE_W'(in_piece_q - PIECE_W'(1))) begin
          piece_cnt_d = '0;
          if (part_cnt_q == PART_W'(part_num_q - PART_W'(1))) begin
            state_d = DONE;
          end else begin
            part_cnt_d = PART_W'(part_cnt_q + PART_W'(1));
            state_d    = LOAD;
          end
        end else begin
          piece_cnt_d = PIECE_W'(piece_cnt_q + PIECE_W'(1));
          state_d     = LOAD;
        end
      end
      DONE: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides every other event outside IDLE.
    if (state_q != IDLE && i_abort) begin
      state_d     = IDLE;
      piece_cnt_d = '0;
      part_cnt_d  = '0;
      err_d       = 1'b0;
    end

    load_req_d   = (state_d == LOAD);
    start_calc_d = (state_d == START);
    done_d       = (state_d == DONE);
    err_out_d    = (state_d == DONE) && err_d;
    busy_d       = (state_d != IDLE);
    ready_d      = (state_d == IDLE);
    pe_en_d      = (state_d == IDLE || err_d) ? '0
                                              : lane_mask(part_cnt_d, part_num_d, last_part_d);
  end

  // State, latched instruction, counters and outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q           <= IDLE;
      in_piece_q        <= '0;
      part_num_q        <= '0;
      last_part_q       <= '0;
      piece_cnt_q       <= '0;
      part_cnt_q        <= '0;
      err_q             <= 1'b0;
      o_load_req        <= 1'b0;
      o_start_calculate <= 1'b0;
      o_busy            <= 1'b0;
      o_done            <= 1'b0;
      o_err             <= 1'b0;
      o_inst_ready      <= 1'b0;
      o_pe_en           <= '0;
    end else begin
      state_q           <= state_d;
      in_piece_q        <= in_piece_d;
      part_num_q        <= part_num_d;
      last_part_q       <= last_part_d;
      piece_cnt_q       <= piece_cnt_d;
      part_cnt_q        <= part_cnt_d;
      err_q             <= err_d;
      o_load_req        <= load_req_d;
      o_start_calculate <= start_calc_d;
      o_busy            <= busy_d;
      o_done            <= done_d;
      o_err             <= err_out_d;
      o_inst_ready      <= ready_d;
      o_pe_en           <= pe_en_d;
    end
  end

endmodule

// File: tb/tb_depthconv_scheduler.sv
// Scoreboard bench for depthconv_scheduler: driver pushes expected pulses,
// a negedge monitor pops and compares whenever the DUT emits one.
module tb_depthconv_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i_inst_valid = 1'b0;
  logic       o_inst_ready;
  logic [7:0] i_in_piece = '0;
  logic [4:0] i_part_num = '0;
  logic [3:0] i_last_part = '0;
  logic       o_load_req;
  logic       i_feature_load_end = 1'b0;
  logic       o_start_calculate;
  logic       i_group_end = 1'b0;
  logic [7:0] o_pe_en;
  logic       i_abort = 1'b0;
  logic       o_busy;
  logic       o_done;
  logic       o_err;

  depthconv_scheduler dut (
    .clk(clk), .rst(rst),
    .i_inst_valid(i_inst_valid), .o_inst_ready(o_inst_ready),
    .i_in_piece(i_in_piece), .i_part_num(i_part_num), .i_last_part(i_last_part),
    .o_load_req(o_load_req), .i_feature_load_end(i_feature_load_end),
    .o_start_calculate(o_start_calculate), .i_group_end(i_group_end),
    .o_pe_en(o_pe_en), .i_abort(i_abort), .o_busy(o_busy),
    .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  localparam int K_LOAD = 0, K_START = 1, K_DONE = 2;

  typedef struct {
    int         kind;
    logic [7:0] pe;
    logic       err;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic push(input int kind, input logic [7:0] pe, input logic err);
    ev_t e;
    e.kind = kind; e.pe = pe; e.err = err;
    exp_q.push_back(e);
  endtask

  // Hand-tabulated lane masks for the final part.
  function automatic logic [7:0] last_mask(input logic [3:0] lp);
    case (lp)
      4'd1: return 8'h01;
      4'd2: return 8'h03;
      4'd3: return 8'h07;
      4'd4: return 8'h0F;
      4'd5: return 8'h1F;
      4'd6: return 8'h3F;
      4'd7: return 8'h7F;
      default: return 8'hFF;
    endcase
  endfunction

  // Monitor: every emitted pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst) begin
      if (o_load_req)        check_event(K_LOAD);
      if (o_start_calculate) check_event(K_START);
      if (o_done)            check_event(K_DONE);
    end
  end

  task automatic check_event(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_pulse: got kind %0d expected none", kind);
    end else begin
      e = exp_q.pop_front();
      chk("pulse_kind", kind, e.kind);
      if (kind == K_DONE) chk("done_err", int'(o_err), int'(e.err));
      else                chk("pe_en", int'(o_pe_en), int'(e.pe));
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic sig(input int kind);
    case (kind)
      K_LOAD:  return o_load_req;
      K_START: return o_start_calculate;
      default: return o_done;
    endcase
  endfunction

  // Wait (bounded) for a pulse and check how many extra cycles it took.
  task automatic wait_pulse(input string name, input int kind, input int exp_k);
    int k = 0;
    while (!sig(kind) && k < 32) begin
      tick();
      k++;
    end
    chk(name, k, exp_k);
  endtask

  task automatic accept(input logic [7:0] ip, input logic [4:0] pn, input logic [3:0] lp);
    tick();
    i_inst_valid = 1'b1; i_in_piece = ip; i_part_num = pn; i_last_part = lp;
    chk("ready_at_accept", int'(o_inst_ready), 1);
    tick();
    i_inst_valid = 1'b0;
  endtask

  task automatic run_inst(input logic [7:0] ip, input logic [4:0] pn,
                          input logic [3:0] lp, input bit spur);
    bit is_err = (ip == 8'd0) || (pn == 5'd0);
    bit first  = 1'b1;
    if (!is_err) begin
      for (int p = 0; p < int'(pn); p++)
        for (int q = 0; q < int'(ip); q++) begin
          logic [7:0] m = (p == int'(pn) - 1) ? last_mask(lp) : 8'hFF;
          push(K_LOAD, m, 1'b0);
          push(K_START, m, 1'b0);
        end
    end
    push(K_DONE, 8'h00, is_err);
    accept(ip, pn, lp);
    if (is_err) begin
      wait_pulse("lat_err_done", K_DONE, 0);
    end else begin
      for (int s = 0; s < int'(ip) * int'(pn); s++) begin
        wait_pulse("lat_load", K_LOAD, first ? 0 : 1);
        first = 1'b0;
        tick();
        if (spur) begin
          i_group_end = 1'b1;
          tick();
          i_group_end = 1'b0;
          chk("no_start_on_group_end", int'(o_start_calculate), 0);
        end
        i_feature_load_end = 1'b1;
        if (spur) i_group_end = 1'b1;
        tick();
        i_feature_load_end = 1'b0;
        i_group_end = 1'b0;
        wait_pulse("lat_start", K_START, 0);
        tick();
        if (spur) begin
          i_feature_load_end = 1'b1;
          i_inst_valid = 1'b1; i_part_num = 5'd0;
          tick();
          i_feature_load_end = 1'b0;
          i_inst_valid = 1'b0;
          chk("ready_while_busy", int'(o_inst_ready), 0);
          chk("no_load_on_load_end", int'(o_load_req), 0);
          tick();
          chk("still_wait_calc", int'(o_load_req), 0);
        end
        i_group_end = 1'b1;
        tick();
        i_group_end = 1'b0;
      end
      wait_pulse("lat_done", K_DONE, 1);
    end
    tick();
    chk("idle_busy", int'(o_busy), 0);
    chk("idle_ready", int'(o_inst_ready), 1);
    chk("idle_pe_en", int'(o_pe_en), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while asserted and right after release.
    #12;
    chk("rst_ready", int'(o_inst_ready), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_pe_en", int'(o_pe_en), 0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_ready", int'(o_inst_ready), 1);
    chk("post_rst_busy", int'(o_busy), 0);

    run_inst(8'd2, 5'd1, 4'd3, 1'b0);   // single part, lanes 0x07
    run_inst(8'd2, 5'd3, 4'd5, 1'b0);   // 3 parts, last part 0x1F
    run_inst(8'd5, 5'd0, 4'd4, 1'b0);   // part_num 0 -> err
    run_inst(8'd0, 5'd2, 4'd4, 1'b0);   // in_piece 0 -> err
    run_inst(8'd1, 5'd2, 4'd0, 1'b1);   // spurious handshakes, last_part 0 -> 0xFF

    // Abort in WAIT_CALC.
    push(K_LOAD, 8'h07, 1'b0);
    push(K_START, 8'h07, 1'b0);
    accept(8'd2, 5'd1, 4'd3);
    wait_pulse("abort_lat_load", K_LOAD, 0);
    tick();
    i_feature_load_end = 1'b1;
    tick();
    i_feature_load_end = 1'b0;
    wait_pulse("abort_lat_start", K_START, 0);
    tick();
    i_abort = 1'b1;
    i_group_end = 1'b1;
    tick();
    i_abort = 1'b0;
    i_group_end = 1'b0;
    chk("abort_busy", int'(o_busy), 0);
    chk("abort_pe_en", int'(o_pe_en), 0);
    chk("abort_ready", int'(o_inst_ready), 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_no_done", int'(o_done), 0);
    end
    run_inst(8'd3, 5'd1, 4'd8, 1'b0);
    run_inst(8'd1, 5'd1, 4'd9, 1'b0);   // >8 -> 0xFF
    run_inst(8'd1, 5'd1, 4'd1, 1'b0);

    // Asynchronous reset during WAIT_LOAD.
    push(K_LOAD, 8'hFF, 1'b0);
    accept(8'd2, 5'd2, 4'd8);
    wait_pulse("rst_lat_load", K_LOAD, 0);
    tick();
    #2 rst = 1'b0;
    #1;
    chk("async_rst_busy", int'(o_busy), 0);
    chk("async_rst_ready", int'(o_inst_ready), 0);
    chk("async_rst_pe_en", int'(o_pe_en), 0);
    tick();
    rst = 1'b1;
    i_feature_load_end = 1'b1;
    tick();
    i_feature_load_end = 1'b0;
    chk("rel_ready", int'(o_inst_ready), 1);
    chk("rel_busy", int'(o_busy), 0);
    for (int i = 0; i < 4; i++) tick();
    run_inst(8'd1, 5'd1, 4'd2, 1'b0);

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/depthconv_scheduler.md
DEPTHCONV_SCHEDULER -- requirements
Module: depthconv_scheduler

Interface
REQ-001 SHALL have: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have: rst  input  1  reset; asynchronous, active-low (0 = reset).
REQ-003 SHALL have: i_inst_valid  input  1  decoded depthwise-conv instruction present.
REQ-004 SHALL have: o_inst_ready  output  1  scheduler idle, instruction accepted when valid&ready.
REQ-005 SHALL have: i_in_piece  input  8  feature pieces per part (0 = illegal).
REQ-006 SHALL have: i_part_num  input  5  channel parts (0 = illegal).
REQ-007 SHALL have: i_last_part  input  4  active channels in final part (legal 1..8; 0 treated as 8).
REQ-008 SHALL have: o_load_req  output  1  one-cycle pulse, request IAGU to load next feature piece.
REQ-009 SHALL have: i_feature_load_end  input  1  one-cycle pulse from IAGU, piece loaded.
REQ-010 SHALL have: o_start_calculate  output  1  one-cycle pulse to weight AGU.
REQ-011 SHALL have: i_group_end  input  1  one-cycle pulse from weight AGU, piece computed.
REQ-012 SHALL have: o_pe_en  output  8  channel-lane enable for NPE, stable for whole part.
REQ-013 SHALL have: i_abort  input  1  synchronous abort.
REQ-014 SHALL have: o_busy  output  1  high in any state except IDLE.
REQ-015 SHALL have: o_done  output  1  one-cycle pulse, instruction finished.
REQ-016 SHALL have: o_err  output  1  one-cycle pulse coincident with o_done for illegal parameters.

Function
REQ-017 States SHALL be IDLE, LOAD, WAIT_LOAD, START, WAIT_CALC, NEXT, DONE.
REQ-018 IDLE: o_inst_ready=1; on i_inst_valid, latch in_piece/part_num/last_part, clear piece_cnt/part_cnt, go LOAD.
REQ-019 Accept with in_piece=0 or part_num=0 SHALL go directly DONE with o_err=1, no load/start pulses.
REQ-020 LOAD: o_load_req=1 for exactly this cycle; next WAIT_LOAD.
REQ-021 WAIT_LOAD: stay until i_feature_load_end=1; then START.
REQ-022 START: o_start_calculate=1 for exactly this cycle; next WAIT_CALC.
REQ-023 WAIT_CALC: stay until i_group_end=1; then NEXT.
REQ-024 NEXT: if piece_cnt==in_piece-1: piece_cnt=0; if part_cnt==part_num-1 go DONE, else part_cnt+1, go LOAD; else piece_cnt+1, go LOAD.
REQ-025 DONE: o_done=1 one cycle; next IDLE.
REQ-026 Latency accept->first o_load_req SHALL be 1 cycle; feature_load_end->o_start_calculate 1 cycle; group_end->next o_load_req 2 cycles.
REQ-027 o_pe_en SHALL be 8'hFF for part_cnt<part_num-1; on last part, low last_part bits set (last_part 0 or >8 -> 8'hFF); 8'h00 in IDLE.
REQ-028 i_feature_load_end outside WAIT_LOAD and i_group_end outside WAIT_CALC SHALL be ignored.
REQ-029 i_feature_load_end and i_group_end both high in WAIT_LOAD SHALL advance only on load_end.
REQ-030 i_abort=1 in any non-IDLE state SHALL go IDLE next cycle, counters cleared, no o_done; abort has priority over all other events.
REQ-031 i_inst_valid while busy SHALL be ignored (o_inst_ready=0).
REQ-032 Counters 8-bit (piece) and 5-bit (part); compare against latched values, no wrap beyond limits.

Reset
REQ-033 rst=0 SHALL asynchronously force IDLE, counters 0, o_load_req=0, o_start_calculate=0, o_pe_en=0, o_busy=0, o_done=0, o_err=0, o_inst_ready=0 while asserted, 1 from first clock after release.
REQ-034 Reset mid-operation SHALL discard latched instruction; no pulse emitted after release until new accept.

Verification
REQ-035 in_piece=2, part_num=1, last_part=3, prompt handshakes -> exactly 2 load_req, 2 start_calculate, o_pe_en=8'h07 throughout, one o_done.
REQ-036 in_piece=2, part_num=3, last_part=5 -> 6 load/start pairs; o_pe_en=8'hFF for pairs 1-4, 8'h1F for 5-6; o_done after 6th group_end +2 cycles.
REQ-037 part_num=0 -> o_done and o_err same cycle 1 cycle after accept, no load_req/start_calculate.
REQ-038 Spurious group_end in WAIT_LOAD and load_end in WAIT_CALC -> no state advance, pulse counts unchanged.
REQ-039 i_abort in WAIT_CALC -> IDLE next cycle, o_busy=0, o_pe_en=0, no o_done; new instruction then runs cleanly.
REQ-040 rst=0 during WAIT_LOAD -> outputs reset immediately (asynchronous), after release IDLE, o_inst_ready=1.
